// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit_if
// Purpose  : Request / HI-LO access bundle between the pipeline and the MDU.
// Revision : 1.0  initial release
// ============================================================================
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic [1:0]       Op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             WrHi;
   logic             WrLo;
   logic [WIDTH-1:0] WrData;
   logic             RdHiLo;
   logic             Busy;
   logic             Stall;
   logic             Done;
   logic             DivZero;
   logic [WIDTH-1:0] Hi;
   logic [WIDTH-1:0] Lo;

   modport master (
      output Start, Op, A, B, WrHi, WrLo, WrData, RdHiLo,
      input  Busy, Stall, Done, DivZero, Hi, Lo
   );

   modport slave (
      input  Start, Op, A, B, WrHi, WrLo, WrData, RdHiLo,
      output Busy, Stall, Done, DivZero, Hi, Lo
   );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Iterative shift-add multiplier / restoring divider with HI/LO.
//            Define MDU_EARLY_OUT_EN to end multiplies after the top set bit of |B|.
// Revision : 1.0  initial release
// ============================================================================
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  wire logic      clk,
   input  wire logic      reset,
   mult_div_unit_if.slave bus
);

   localparam int         CNT_W   = $clog2(WIDTH + 1);
   localparam logic [1:0] OP_MULT = 2'd0;
   localparam logic [1:0] OP_DIV  = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [1:0]           op_q, op_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplr_q, mplr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 neg_q, neg_d;
   logic                 sign_a_q, sign_a_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 done_q, done_d;
   logic                 div_zero_q, div_zero_d;

   logic                 is_signed;
   logic [WIDTH-1:0]     mag_a;
   logic [WIDTH-1:0]     mag_b;
   logic [CNT_W-1:0]     mul_iters;
   logic [WIDTH:0]       rem_sh;
   logic [WIDTH:0]       diff;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     quo;
   logic [WIDTH-1:0]     rem;

   assign is_signed = ~bus.Op[0];
   assign mag_a     = (is_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
   assign mag_b     = (is_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;

`ifdef MDU_EARLY_OUT_EN
   // Once the multiplier magnitude runs out of set bits the rest of the sum is zero.
   always_comb begin
      mul_iters = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (mag_b[i]) begin
            mul_iters = CNT_W'(i + 1);
         end
      end
   end
`else
   assign mul_iters = CNT_W'(WIDTH);
`endif

   // Restoring step: partial remainder sits in acc_q upper half, dividend bits below.
   assign rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign diff   = rem_sh - {1'b0, mplr_q};

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      acc_d      = acc_q;
      mcand_d    = mcand_q;
      mplr_d     = mplr_q;
      cnt_d      = cnt_q;
      neg_d      = neg_q;
      sign_a_d   = sign_a_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
      prod       = '0;
      quo        = '0;
      rem        = '0;

      case (state_q)
         IDLE: begin
            if (bus.Start) begin
               op_d     = bus.Op;
               sign_a_d = is_signed & bus.A[WIDTH-1];
               neg_d    = is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
               mplr_d   = mag_b;
               if (bus.Op[1]) begin
                  // Raw dividend is parked in mcand for the divide-by-zero result.
                  acc_d   = {{WIDTH{1'b0}}, mag_a};
                  mcand_d = {{WIDTH{1'b0}}, bus.A};
                  cnt_d   = CNT_W'(WIDTH);
                  state_d = CALC;
               end else begin
                  acc_d   = '0;
                  mcand_d = {{WIDTH{1'b0}}, mag_a};
                  cnt_d   = mul_iters;
                  state_d = (mul_iters == '0) ? FIX : CALC;
               end
            end else begin
               if (bus.WrHi) begin
                  hi_d = bus.WrData;
               end
               if (bus.WrLo) begin
                  lo_d = bus.WrData;
               end
            end
         end

         CALC: begin
            if (op_q[1]) begin
               if (!diff[WIDTH]) begin
                  acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               if (mplr_q[0]) begin
                  acc_d = acc_q + mcand_q;
               end
               mcand_d = mcand_q << 1;
               mplr_d  = mplr_q >> 1;
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = FIX;
            end
         end

         FIX: begin
            if (op_q[1]) begin
               quo = acc_q[WIDTH-1:0];
               rem = acc_q[2*WIDTH-1:WIDTH];
               if (mplr_q == '0) begin
                  lo_d       = '1;
                  hi_d       = mcand_q[WIDTH-1:0];
                  div_zero_d = 1'b1;
               end else begin
                  // Most-negative / -1 falls out naturally: quotient magnitude equals A.
                  lo_d = (op_q == OP_DIV && neg_q)    ? -quo : quo;
                  hi_d = (op_q == OP_DIV && sign_a_q) ? -rem : rem;
               end
            end else begin
               prod = (op_q == OP_MULT && neg_q) ? -acc_q : acc_q;
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         op_q       <= '0;
         acc_q      <= '0;
         mcand_q    <= '0;
         mplr_q     <= '0;
         cnt_q      <= '0;
         neg_q      <= 1'b0;
         sign_a_q   <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         acc_q      <= acc_d;
         mcand_q    <= mcand_d;
         mplr_q     <= mplr_d;
         cnt_q      <= cnt_d;
         neg_q      <= neg_d;
         sign_a_q   <= sign_a_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign bus.Busy    = (state_q != IDLE);
   assign bus.Stall   = bus.Busy & (bus.RdHiLo | bus.Start | bus.WrHi | bus.WrLo);
   assign bus.Done    = done_q;
   assign bus.DivZero = div_zero_q;
   assign bus.Hi      = hi_q;
   assign bus.Lo      = lo_q;

endmodule
`default_nettype wire
